// File: rtl/muldiv_unit_if.sv
// Request/response bundle between EX-stage control and the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (output start, func, op_a, op_b,
                    input  busy, done, rd_data, hi_out, lo_out);
    modport slave  (input  start, func, op_a, op_b,
                    output busy, done, rd_data, hi_out, lo_out);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle one.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [2:0] {P_MFHI, P_MFLO, P_MTHI, P_MTLO, P_DIV0, P_FMUL} pend_t;

    state_t             state_reg;
    pend_t              pend_kind_reg;
    logic               pend_reg;
    logic [CW-1:0]      cnt_reg;
    logic               iter_done_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   src_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic               neg_hi_reg;
    logic               neg_lo_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   rd_data_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.rd_data = rd_data_reg;
    assign bus.hi_out  = hi_reg;
    assign bus.lo_out  = lo_reg;

    // Bit 0 of the funct code separates the signed (0) and unsigned (1) variants.
    logic             signed_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    assign signed_op = ~bus.func[0];
    assign mag_a = (signed_op && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign mag_b = (signed_op && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

    // Multiply step: acc = {partial high, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg & {WIDTH{acc_reg[0]}}};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;
    assign prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
    assign rem_fix  = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    assign quo_fix  = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    logic [2*WIDTH-1:0] fast_fix;
    assign fast_prod = {{WIDTH{1'b0}}, opnd_reg} * {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]};
    assign fast_fix  = neg_lo_reg ? -fast_prod : fast_prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pend_kind_reg <= P_MFHI;
            pend_reg      <= 1'b0;
            cnt_reg       <= '0;
            iter_done_reg <= 1'b0;
            opnd_reg      <= '0;
            src_reg       <= '0;
            acc_reg       <= '0;
            neg_hi_reg    <= 1'b0;
            neg_lo_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_data_reg   <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pend_reg) begin
                        // Single-cycle ops commit one edge after acceptance.
                        pend_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                        case (pend_kind_reg)
                            P_MFHI: rd_data_reg <= hi_reg;
                            P_MFLO: rd_data_reg <= lo_reg;
                            P_MTHI: hi_reg <= src_reg;
                            P_MTLO: lo_reg <= src_reg;
                            P_DIV0: begin
                                hi_reg <= src_reg;
                                lo_reg <= '1;
                            end
`ifdef MULDIV_FAST_MULT_EN
                            P_FMUL: begin
                                hi_reg <= fast_fix[2*WIDTH-1:WIDTH];
                                lo_reg <= fast_fix[WIDTH-1:0];
                            end
`endif
                            default: ;
                        endcase
                    end else if (bus.start) begin
                        neg_hi_reg    <= signed_op & bus.op_a[WIDTH-1];
                        neg_lo_reg    <= signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        cnt_reg       <= CW'(WIDTH - 1);
                        iter_done_reg <= 1'b0;
                        src_reg       <= bus.op_a;
                        case (bus.func)
                            F_MULT, F_MULTU: begin
                                opnd_reg <= mag_a;
                                acc_reg  <= {{WIDTH{1'b0}}, mag_b};
`ifdef MULDIV_FAST_MULT_EN
                                pend_reg      <= 1'b1;
                                pend_kind_reg <= P_FMUL;
`else
                                state_reg <= MUL;
                                busy_reg  <= 1'b1;
`endif
                            end
                            F_DIV, F_DIVU: begin
                                opnd_reg <= mag_b;
                                acc_reg  <= {{WIDTH{1'b0}}, mag_a};
                                if (bus.op_b == '0) begin
                                    pend_reg      <= 1'b1;
                                    pend_kind_reg <= P_DIV0;
                                end else begin
                                    state_reg <= DIV;
                                    busy_reg  <= 1'b1;
                                end
                            end
                            F_MFHI: begin
                                pend_reg      <= 1'b1;
                                pend_kind_reg <= P_MFHI;
                            end
                            F_MFLO: begin
                                pend_reg      <= 1'b1;
                                pend_kind_reg <= P_MFLO;
                            end
                            F_MTHI: begin
                                pend_reg      <= 1'b1;
                                pend_kind_reg <= P_MTHI;
                            end
                            F_MTLO: begin
                                pend_reg      <= 1'b1;
                                pend_kind_reg <= P_MTLO;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (!iter_done_reg) begin
                        acc_reg <= (state_reg == MUL) ? mul_next : div_next;
                        if (cnt_reg == '0)
                            iter_done_reg <= 1'b1;
                        else
                            cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        // Sign correction is folded into the commit edge.
                        if (state_reg == MUL) begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end else begin
                            hi_reg <= rem_fix;
                            lo_reg <= quo_fix;
                        end
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
